// File: rtl/shift_seq_ctrl.sv
// Shift-strobe sequencer for the board shift register: debounced button, burst, flush and optional auto-step.
// Auto-step timer is only built when SHIFT_CTRL_AUTO_EN is defined; ports are identical either way.
module shift_seq_ctrl #(
  parameter int DB_CYCLES = 1250000,
  parameter int DEPTH     = 3,
  parameter int PER_W     = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         btn_n,
  input  logic                         mode_auto,
  input  logic [PER_W-1:0]             period,
  input  logic                         burst_go,
  input  logic [3:0]                   burst_len,
  input  logic                         flush,
  output logic                         shift_en,
  output logic                         load_zero,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         out_valid,
  output logic                         busy,
  output logic [15:0]                  shift_cnt
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int DB_W  = $clog2(DB_CYCLES+1);
  localparam int REM_W = (OCC_W > 4) ? OCC_W : 4;
  localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(DEPTH);
  localparam logic [REM_W-1:0] FLUSH_REM = REM_W'(DEPTH-1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES-1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd1, ST_FLUSH = 2'd2} state_t;

  state_t            state_r;
  logic              sync1_r, sync2_r, db_r, db_d_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic [REM_W-1:0]  rem_r;
  logic              press_s;
  logic              tick_s;

  function automatic logic [OCC_W-1:0] occ_inc(input logic [OCC_W-1:0] occ);
    if (occ == OCC_MAX) begin
      return occ;
    end else begin
      return occ + OCC_W'(1);
    end
  endfunction

  // Button synchroniser and debouncer; reset parks every stage at "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      db_r     <= 1'b1;
      db_d_r   <= 1'b1;
      db_cnt_r <= {DB_W{1'b0}};
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      if (sync2_r == db_r) begin
        db_cnt_r <= {DB_W{1'b0}};
      end else if (db_cnt_r == DB_LAST) begin
        db_r     <= sync2_r;
        db_cnt_r <= {DB_W{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end
  end

  assign press_s = db_d_r & ~db_r;

`ifdef SHIFT_CTRL_AUTO_EN
  logic [PER_W-1:0] timer_r;
  logic [PER_W-1:0] per_m1_s;
  logic             timer_run_s;

  assign per_m1_s    = (period == {PER_W{1'b0}}) ? {PER_W{1'b0}} : period - PER_W'(1);
  assign timer_run_s = (state_r == ST_IDLE) && mode_auto;
  // >= so that shrinking the period with a large count ticks at once
  assign tick_s      = timer_run_s && (timer_r >= per_m1_s);

  // Auto-step timer, held at zero outside auto-mode IDLE and reloaded on every tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= {PER_W{1'b0}};
    end else if (!timer_run_s || tick_s) begin
      timer_r <= {PER_W{1'b0}};
    end else begin
      timer_r <= timer_r + PER_W'(1);
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{mode_auto, period};
  assign tick_s   = 1'b0;
`endif

  // Command sequencer: accepts one command in IDLE, then streams its strobes with registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rem_r     <= {REM_W{1'b0}};
      shift_en  <= 1'b0;
      load_zero <= 1'b0;
      busy      <= 1'b0;
      occupancy <= {OCC_W{1'b0}};
      out_valid <= 1'b0;
      shift_cnt <= 16'd0;
    end else begin
      shift_en  <= 1'b0;
      load_zero <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (flush) begin
            state_r   <= ST_FLUSH;
            rem_r     <= FLUSH_REM;
            busy      <= 1'b1;
            shift_en  <= 1'b1;
            load_zero <= 1'b1;
            shift_cnt <= shift_cnt + 16'd1;
            if (FLUSH_REM == {REM_W{1'b0}}) begin
              occupancy <= {OCC_W{1'b0}};
              out_valid <= 1'b0;
            end else begin
              occupancy <= occupancy;
            end
          end else if (burst_go) begin
            // a zero-length burst still wins priority but emits nothing
            if (burst_len != 4'd0) begin
              state_r   <= ST_BURST;
              rem_r     <= REM_W'(burst_len) - REM_W'(1);
              busy      <= 1'b1;
              shift_en  <= 1'b1;
              occupancy <= occ_inc(occupancy);
              out_valid <= (occ_inc(occupancy) == OCC_MAX);
              shift_cnt <= shift_cnt + 16'd1;
            end else begin
              busy <= 1'b0;
            end
          end else if (press_s || tick_s) begin
            busy      <= 1'b0;
            shift_en  <= 1'b1;
            occupancy <= occ_inc(occupancy);
            out_valid <= (occ_inc(occupancy) == OCC_MAX);
            shift_cnt <= shift_cnt + 16'd1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_BURST: begin
          if (rem_r == {REM_W{1'b0}}) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            rem_r     <= rem_r - REM_W'(1);
            shift_en  <= 1'b1;
            occupancy <= occ_inc(occupancy);
            out_valid <= (occ_inc(occupancy) == OCC_MAX);
            shift_cnt <= shift_cnt + 16'd1;
          end
        end
        ST_FLUSH: begin
          if (rem_r == {REM_W{1'b0}}) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            rem_r     <= rem_r - REM_W'(1);
            shift_en  <= 1'b1;
            load_zero <= 1'b1;
            shift_cnt <= shift_cnt + 16'd1;
            if (rem_r == REM_W'(1)) begin
              occupancy <= {OCC_W{1'b0}};
              out_valid <= 1'b0;
            end else begin
              occupancy <= occupancy;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_shift_seq_ctrl;
  localparam int DB    = 4;
  localparam int DEPTH = 3;
  localparam int PER_W = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              btn_n = 1'b1;
  logic              mode_auto = 1'b0;
  logic [PER_W-1:0]  period = 24'd0;
  logic              burst_go = 1'b0;
  logic [3:0]        burst_len = 4'd0;
  logic              flush = 1'b0;
  logic              shift_en, load_zero, out_valid, busy;
  logic [1:0]        occupancy;
  logic [15:0]       shift_cnt;

  int n_checks = 0;
  int n_errors = 0;

  shift_seq_ctrl #(.DB_CYCLES(DB), .DEPTH(DEPTH), .PER_W(PER_W)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .mode_auto(mode_auto), .period(period),
    .burst_go(burst_go), .burst_len(burst_len), .flush(flush),
    .shift_en(shift_en), .load_zero(load_zero), .occupancy(occupancy),
    .out_valid(out_valid), .busy(busy), .shift_cnt(shift_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: sequences are queues of pending load_zero bits.
  bit syncq[$] = '{1'b1, 1'b1};
  bit m_db = 1'b1, m_fell = 1'b0, m_in_seq = 1'b0;
  int m_run = 0, m_timer = 0, m_occ = 0, m_cnt = 0;
  bit pend[$];
  bit e_se = 1'b0, e_lz = 1'b0, e_busy = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic emit(input bit lz);
    e_se  = 1'b1;
    e_lz  = lz;
    m_cnt = (m_cnt + 1) % 65536;
    if (!lz) m_occ = (m_occ < DEPTH) ? m_occ + 1 : DEPTH;
    else if (pend.size() == 0) m_occ = 0;
  endtask

  // Predict the outputs that follow the next rising edge from the inputs now applied.
  task automatic model_step();
    bit press, tick, s2;
    int lim;
    e_se = 1'b0;
    e_lz = 1'b0;
    if (rst) begin
      syncq = '{1'b1, 1'b1};
      m_db = 1'b1; m_fell = 1'b0; m_in_seq = 1'b0;
      m_run = 0; m_timer = 0; m_occ = 0; m_cnt = 0;
      pend.delete();
      e_busy = 1'b0;
      return;
    end
    press  = m_fell;
    m_fell = 1'b0;
    s2 = syncq.pop_front();
    syncq.push_back(btn_n);
    if (s2 != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db  = s2;
        m_run = 0;
        m_fell = (s2 == 1'b0);
      end
    end else begin
      m_run = 0;
    end
    tick = 1'b0;
`ifdef SHIFT_CTRL_AUTO_EN
    if (!m_in_seq && mode_auto) begin
      lim = (period == 0) ? 0 : int'(period) - 1;
      if (m_timer >= lim) begin
        tick = 1'b1;
        m_timer = 0;
      end else begin
        m_timer++;
      end
    end else begin
      m_timer = 0;
    end
`else
    lim = 0;
`endif
    if (m_in_seq) begin
      if (pend.size() > 0) emit(pend.pop_front());
      else m_in_seq = 1'b0;
    end else if (flush) begin
      repeat (DEPTH) pend.push_back(1'b1);
      m_in_seq = 1'b1;
      emit(pend.pop_front());
    end else if (burst_go) begin
      if (burst_len != 0) begin
        repeat (int'(burst_len)) pend.push_back(1'b0);
        m_in_seq = 1'b1;
        emit(pend.pop_front());
      end
    end else if (press || tick) begin
      emit(1'b0);
    end
    e_busy = m_in_seq;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_val("shift_en", shift_en, e_se);
    check_val("load_zero", load_zero, e_lz);
    check_val("busy", busy, e_busy);
    check_val("occupancy", occupancy, m_occ);
    check_val("out_valid", out_valid, (m_occ == DEPTH));
    check_val("shift_cnt", shift_cnt, m_cnt);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic press_btn();
    btn_n = 1'b0; run(10);
    btn_n = 1'b1; run(10);
  endtask

  initial begin
    int first, pulses, cnt0;
    // reset state
    rst = 1'b1; run(2);
    rst = 1'b0;
    check_val("rst_shift_en", shift_en, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_occ", occupancy, 0);
    check_val("rst_cnt", shift_cnt, 0);

    // bounced press: low, high, low then stable
    btn_n = 1'b0; cycle();
    btn_n = 1'b1; cycle();
    btn_n = 1'b0;
    first = -1; pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      cycle();
      if (shift_en === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check_val("press_latency", first, 7);
    check_val("press_pulses", pulses, 1);
    check_val("press_cnt", shift_cnt, 1);
    check_val("press_occ", occupancy, 1);
    btn_n = 1'b1; run(10);
    check_val("release_cnt", shift_cnt, 1);

    // four clean presses from reset: occupancy saturates
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      press_btn();
      check_val("press_occ_seq", occupancy, (i < 3) ? i : 3);
      check_val("press_valid_seq", out_valid, (i >= 3));
    end
    check_val("press4_cnt", shift_cnt, 4);

    // burst of 5 with a press event landing inside it
    cnt0 = shift_cnt;
    btn_n = 1'b0; run(3);
    burst_go = 1'b1; burst_len = 4'd5;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      burst_go = 1'b0;
      check_val("burst_se_win", shift_en, (i <= 5));
      check_val("burst_busy_win", busy, (i <= 5));
    end
    btn_n = 1'b1; run(12);
    check_val("burst_cnt_delta", shift_cnt - cnt0[15:0], 5);

    // flush and burst_go together from full occupancy
    check_val("pre_flush_occ", occupancy, 3);
    flush = 1'b1; burst_go = 1'b1; burst_len = 4'd5;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      flush = 1'b0; burst_go = 1'b0;
      check_val("flush_se", shift_en, (i <= 3));
      check_val("flush_lz", load_zero, (i <= 3));
      check_val("flush_occ", occupancy, (i >= 3) ? 0 : 3);
    end

    // auto step, period 4 then period 0
    period = 24'd4; mode_auto = 1'b1; pulses = 0;
    for (int i = 0; i < 20; i++) begin cycle(); pulses += int'(shift_en); end
`ifdef SHIFT_CTRL_AUTO_EN
    check_val("auto_p4_pulses", pulses, 5);
`else
    check_val("auto_p4_pulses", pulses, 0);
`endif
    period = 24'd0; pulses = 0;
    for (int i = 0; i < 10; i++) begin cycle(); pulses += int'(shift_en); end
`ifdef SHIFT_CTRL_AUTO_EN
    check_val("auto_p0_pulses", pulses, 10);
`else
    check_val("auto_p0_pulses", pulses, 0);
`endif
    mode_auto = 1'b0; run(3);

    // reset on the second pulse of a 10-shift burst
    burst_go = 1'b1; burst_len = 4'd10; cycle();
    burst_go = 1'b0; cycle();
    check_val("burst10_second", shift_en, 1);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_val("midrst_se", shift_en, 0);
    check_val("midrst_lz", load_zero, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_occ", occupancy, 0);
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_cnt", shift_cnt, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin cycle(); pulses += int'(shift_en); end
    check_val("post_rst_pulses", pulses, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) btn_n = ~btn_n;
      if ($urandom_range(0, 99) == 0) mode_auto = ~mode_auto;
      if ($urandom_range(0, 49) == 0) period = 24'($urandom_range(0, 6));
      burst_go  = ($urandom_range(0, 14) == 0);
      burst_len = 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; burst_go = 1'b0; flush = 1'b0;
    run(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the 8-bit, DEPTH-stage board shift register. It turns a raw active-low push button, an optional free-running auto-step timer, burst commands and flush commands into single-cycle `shift_en` pulses. It also reports pipeline occupancy. It sits between the board keys/switches and the shift-register datapath, replacing ad-hoc edge detection in the top level.

## Interface
- `DB_CYCLES`, 1250000: consecutive stable cycles required to accept a button level change (10 ms at 125 MHz).
- `DEPTH`, 3: shift-register stage count; sets flush length and occupancy ceiling.
- `PER_W`, 24: auto-step period width.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_n` in 1: raw asynchronous button, low = pressed.
- `mode_auto` in 1: enable the auto-step timer.
- `period` in PER_W: auto-step period in clk cycles; 0 is treated as 1.
- `burst_go` in 1: single-cycle request to start a burst.
- `burst_len` in 4: shifts per burst, sampled on `burst_go`.
- `flush` in 1: single-cycle request to shift DEPTH zeros through the register.
- `shift_en` out 1: registered one-cycle shift strobe to the datapath.
- `load_zero` out 1: with `shift_en`, tells the datapath to load 0 instead of the switch data.
- `occupancy` out clog2(DEPTH+1): real entries loaded since the last flush/reset, saturating at DEPTH.
- `out_valid` out 1: `occupancy == DEPTH`.
- `busy` out 1: FSM is in BURST or FLUSH.
- `shift_cnt` out 16: total `shift_en` pulses, wraps at 65535→0.

## Operation
- **Button path**
  - Two-flop synchronizer, then a debounce counter. The debounced level changes only after the synchronized level differs from it for DB_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A press event is the debounced 1→0 transition. Release generates nothing.
- **FSM states**
  - IDLE: handles the single-shot sources.
  - BURST: remaining-count register.
  - FLUSH: remaining-count register.
- **IDLE priority, same cycle:** flush > burst_go > press event > auto tick. Lower-priority events in that cycle are dropped, not queued.
- **flush:** go to FLUSH with count DEPTH. Emit DEPTH consecutive `shift_en` pulses, each with `load_zero`=1. On the last pulse, `occupancy` clears to 0. Return to IDLE.
- **burst_go**
  - `burst_len`=0 is a no-op and the FSM stays in IDLE.
  - Otherwise go to BURST and emit `burst_len` consecutive pulses with `load_zero`=0. Return to IDLE after the last pulse.
- **Press event or auto tick:** one pulse, `load_zero`=0.
- **Outside IDLE:** press events, auto ticks, `burst_go` and `flush` are all ignored.
- **Occupancy:** each `shift_en` with `load_zero`=0 increments `occupancy`, saturating at DEPTH. Pulses with `load_zero`=1 leave it unchanged until the final flush pulse.
- **Auto timer**
  - Counts only in IDLE with `mode_auto`=1. Otherwise it is held at 0.
  - Ticks when the count reaches max(`period`,1)−1, then reloads 0.
  - A tick that loses priority is dropped and the timer still reloads.
- **Reset**
  - Effective the cycle after `rst` is sampled high, including mid-burst or mid-flush.
  - State: IDLE, all counters 0, `shift_en`/`load_zero`/`busy` = 0, `occupancy` = 0, `shift_cnt` = 0.
  - Synchronizer and debounced level are forced to 1 (released), so no spurious press follows reset.

## Timing
- All outputs are registered.
- Press latency:
  - Raw `btn_n` falls at cycle 0 and stays stable.
  - The synchronized level is low at cycle 2.
  - The debounced level falls at cycle 2+DB_CYCLES.
  - `shift_en` is high at cycle 3+DB_CYCLES.
- `burst_go` or `flush` at cycle t: first pulse at t+1, last at t+N (N = `burst_len` or DEPTH). `busy` is high for cycles t+1..t+N.
- The earliest new command is accepted at t+N+1, giving its first pulse at t+N+2 (one idle cycle between sequences).
- Auto mode, `period`=P≥1, entering IDLE with `mode_auto`=1 at cycle 0: pulses at cycles P, 2P, …. With P=1, a pulse every cycle.
- A `period` change takes effect at the next comparison; a count already ≥ new period−1 ticks immediately.
- `shift_cnt`, `occupancy` and `out_valid` update in the same cycle `shift_en` is high.

## Configuration
- `SHIFT_CTRL_AUTO_EN` defined: the auto-step timer and `period` compare are present, as described above.
- Not defined:
  - Timer logic is omitted; `mode_auto` and `period` are ignored and no auto ticks occur.
  - Port list is unchanged.

## Test plan
All scenarios use DB_CYCLES=4, DEPTH=3.
- Reset then `btn_n` low with 2-cycle bounce (low, high, low, stable low): exactly one `shift_en`, 7 cycles after the final fall. `shift_cnt`=1, `occupancy`=1.
- Three clean presses: `occupancy` 1,2,3, `out_valid`=1 after the third. A fourth press keeps `occupancy`=3 and `shift_cnt`=4.
- `burst_len`=5, `burst_go` at t: `shift_en` high t+1..t+5, `busy` same window, `shift_cnt`+5. A press during the burst produces no extra pulse.
- `flush` and `burst_go` in the same cycle from `occupancy`=3: 3 pulses with `load_zero`=1, no burst. `occupancy`=0 on the third pulse.
- Auto mode with `period`=4 for 20 cycles: pulses every 4th cycle, 5 total. `period`=0: a pulse every cycle. Macro undefined: no pulses.
- `rst` asserted on the 2nd pulse of a 10-shift burst: next cycle all outputs 0, IDLE, no further pulses. With `btn_n` held high, no press event after reset.
